// File: rtl/conv_filt_pkg.sv
// Shared types and constants for the convolution line-timing path.
package conv_filt_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, VERIFY, LOCKED} state_t;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_LOCK_N   = 2;
  localparam int DEF_UNLOCK_N = 2;
  localparam int DEF_KERNEL_R = 2;

  // Bit positions inside the {top,bottom,left,right} border word
  localparam int BRD_T = 3;
  localparam int BRD_B = 2;
  localparam int BRD_L = 1;
  localparam int BRD_R = 0;

endpackage

// File: rtl/line_timing_ctrl_if.sv
// Receiver-timing inputs and sequencer outputs of the line timing controller.
interface line_timing_ctrl_if
  import conv_filt_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              rx_hs;
  logic              rx_vs;
  logic              rx_dv;
  logic [7:0]        sw;
  logic              locked;
  logic [ADDR_W-1:0] line_len;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        coef_sel;
  logic [3:0]        border;

  modport master (
    output rx_hs, rx_vs, rx_dv, sw,
    input  locked, line_len, addr, coef_sel, border
  );

  modport slave (
    input  rx_hs, rx_vs, rx_dv, sw,
    output locked, line_len, addr, coef_sel, border
  );
endinterface

// File: rtl/sync_edge_det.sv
// Single-register edge detector: rise/fall compare the live input with last cycle's sample.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/line_timing_ctrl.sv
// Line-period lock, cyclic line-buffer address, pixel position/border flags and
// frame-synchronous filter select for the 5-line convolution path.
module line_timing_ctrl
  import conv_filt_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOCK_N   = DEF_LOCK_N,
  parameter int UNLOCK_N = DEF_UNLOCK_N,
  parameter int KERNEL_R = DEF_KERNEL_R
) (
  input logic               clk,
  input logic               rst,
  line_timing_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] KR        = ADDR_W'(KERNEL_R);
  localparam logic [7:0]        LOCK_TH   = 8'(LOCK_N);
  localparam logic [7:0]        UNLOCK_TH = 8'(UNLOCK_N);

  logic hs_rise, vs_rise, dv_rise, dv_fall;
  logic hs_fall_unused, vs_fall_unused;

  sync_edge_det u_hs (.clk(clk), .rst(rst), .d(bus.rx_hs), .rise(hs_rise), .fall(hs_fall_unused));
  sync_edge_det u_vs (.clk(clk), .rst(rst), .d(bus.rx_vs), .rise(vs_rise), .fall(vs_fall_unused));
  sync_edge_det u_dv (.clk(clk), .rst(rst), .d(bus.rx_dv), .rise(dv_rise), .fall(dv_fall));

  state_t            state, state_n;
  logic [ADDR_W-1:0] period, cand, cand_n, line_len_r, line_len_n, addr_r, addr_n;
  logic [7:0]        match_cnt, match_n, miss_cnt, miss_n, coef_r;
  logic              locked_r, sat;

  // A saturated period means hs has gone away; an hs rise that same cycle still counts.
  assign sat = (period == CNT_MAX) && !hs_rise;

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    line_len_n = line_len_r;
    if (sat) begin
      state_n = IDLE;
    end else if (hs_rise) begin
      case (state)
        IDLE: state_n = MEASURE;
        MEASURE: begin
          state_n = VERIFY;
          cand_n  = period;
          match_n = 8'd1;
        end
        VERIFY: begin
          if (period == cand) begin
            match_n = match_cnt + 8'd1;
            if (match_n >= LOCK_TH) begin
              state_n    = LOCKED;
              line_len_n = cand;
              miss_n     = '0;
            end
          end else begin
            cand_n  = period;
            match_n = 8'd1;
          end
        end
        LOCKED: begin
          if (period == line_len_r) begin
            miss_n = '0;
          end else begin
            miss_n = miss_cnt + 8'd1;
            if (miss_n >= UNLOCK_TH) begin
              state_n = VERIFY;
              cand_n  = period;
              match_n = 8'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Free-running once locked; zero on lock entry and whenever not locked.
    addr_n = '0;
    if (state == LOCKED && state_n == LOCKED)
      addr_n = (addr_r >= line_len_r - ONE) ? '0 : addr_r + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period     <= '0;
      cand       <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      line_len_r <= '0;
      addr_r     <= '0;
      locked_r   <= 1'b0;
      coef_r     <= '0;
    end else begin
      state      <= state_n;
      period     <= hs_rise ? ONE : ((period == CNT_MAX) ? CNT_MAX : period + ONE);
      cand       <= cand_n;
      match_cnt  <= match_n;
      miss_cnt   <= miss_n;
      line_len_r <= line_len_n;
      addr_r     <= addr_n;
      locked_r   <= (state_n == LOCKED);
      if (vs_rise && locked_r) coef_r <= bus.sw;
    end
  end

  logic [ADDR_W-1:0] col, row, act_w, act_h, pix_col, pix_row;
  logic [3:0]        border_r, border_n;

  // col still holds the previous line's count on the dv rise cycle, so index the pixel from 0 there.
  assign pix_col = dv_rise ? '0 : col;
  assign pix_row = vs_rise ? '0 : row;

  always_comb begin
    border_n = '0;
    if (bus.rx_dv) begin
      border_n[BRD_L] = pix_col < KR;
      border_n[BRD_R] = (act_w != '0) && ((act_w < KR) || (pix_col >= act_w - KR));
      border_n[BRD_T] = pix_row < KR;
      border_n[BRD_B] = (act_h != '0) && ((act_h < KR) || (pix_row >= act_h - KR));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      act_w    <= '0;
      act_h    <= '0;
      border_r <= '0;
    end else begin
      border_r <= border_n;
      if (dv_rise)                          col <= ONE;
      else if (bus.rx_dv && col != CNT_MAX) col <= col + ONE;
      if (dv_fall) act_w <= col;
      if (vs_rise) begin
        row   <= '0;
        act_h <= row;
      end else if (dv_fall && row != CNT_MAX) begin
        row <= row + ONE;
      end
    end
  end

  assign bus.locked   = locked_r;
  assign bus.line_len = line_len_r;
  assign bus.addr     = addr_r;
  assign bus.coef_sel = coef_r;
  assign bus.border   = border_r;
endmodule

// File: tb/tb_line_timing_ctrl.sv
// Directed + randomized bench for line_timing_ctrl against a timestamp/queue reference model.
module tb_line_timing_ctrl;
  localparam int AW  = 12;
  localparam int LN  = 2;
  localparam int UN  = 2;
  localparam int KR  = 2;
  localparam int SAT = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;

  line_timing_ctrl_if #(.ADDR_W(AW)) bus();

  line_timing_ctrl #(.ADDR_W(AW), .LOCK_N(LN), .UNLOCK_N(UN), .KERNEL_R(KR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Reference model: hs-rise timestamps, a queue of measured periods while acquiring
  bit       hs_p, vs_p;
  int       m_last, m_len, m_lock_edge, m_misses;
  bit       m_locked, m_have_ref;
  int       q[$];
  logic [7:0] m_coef;

  // Pixel coordinates the bench is currently driving and the frame geometry
  int px, py, g_w, g_h, frames_ok;
  bit bok;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic bit tail_equal();
    if (q.size() < LN) return 1'b0;
    for (int i = 1; i < LN; i++)
      if (q[q.size() - 1 - i] != q[q.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int per;
    bit hs_r, vs_r, was_locked;
    if (rst) begin
      hs_p = 0; vs_p = 0;
      m_locked = 0; m_have_ref = 0; q.delete();
      m_len = 0; m_misses = 0; m_coef = '0;
      m_last = k + 1;
    end else begin
      hs_r = bus.rx_hs && !hs_p;
      vs_r = bus.rx_vs && !vs_p;
      per  = k - m_last;
      if (per > SAT) per = SAT;
      was_locked = m_locked;
      if (vs_r && was_locked) m_coef = bus.sw;
      if (per == SAT && !hs_r) begin
        m_locked = 0; m_have_ref = 0; q.delete();
      end else if (hs_r) begin
        m_last = k;
        if (m_locked) begin
          if (per == m_len) m_misses = 0;
          else              m_misses++;
          if (m_misses >= UN) begin
            m_locked = 0; q.delete(); q.push_back(per); m_have_ref = 1;
          end
        end else if (!m_have_ref) begin
          m_have_ref = 1;
        end else begin
          q.push_back(per);
          if (tail_equal()) begin
            m_locked = 1; m_len = per; m_lock_edge = k; m_misses = 0; q.delete();
          end
        end
      end
      hs_p = bus.rx_hs;
      vs_p = bus.rx_vs;
    end
  endtask

  task automatic step();
    int ea;
    logic [3:0] eb;
    @(posedge clk);
    k++;
    model_edge();
    #1;
    ea = m_locked ? (k - m_lock_edge) % m_len : 0;
    check("locked",   bus.locked,   m_locked);
    check("line_len", bus.line_len, m_len);
    check("addr",     bus.addr,     ea);
    check("coef_sel", bus.coef_sel, m_coef);
    if (rst || !bus.rx_dv) begin
      check("border_idle", bus.border, 0);
    end else if (bok) begin
      eb = {py < KR, py >= g_h - KR, px < KR, px >= g_w - KR};
      check("border", bus.border, eb);
    end
  endtask

  task automatic drive(bit h, bit v, bit d);
    bus.rx_hs = h;
    bus.rx_vs = v;
    bus.rx_dv = d;
    step();
  endtask

  // hs high for 2 clocks, vs (frame start) for 3, W pixels from column offset 4
  task automatic line_seg(int W, bit vs_start, int y, int c0, int c1);
    for (int c = c0; c < c1; c++) begin
      px = c - 4;
      py = y;
      drive(c < 2, vs_start && c < 3, W > 0 && c >= 4 && c < 4 + W);
    end
  endtask

  task automatic line(int P, int W, bit vs_start, int y);
    line_seg(W, vs_start, y, 0, P);
  endtask

  task automatic frame(int P, int W, int H, int sw_mid);
    if (W != g_w || H != g_h) begin
      g_w = W; g_h = H; frames_ok = 0;
    end
    frames_ok++;
    bok = frames_ok >= 2;
    for (int y = 0; y < H; y++) begin
      if (sw_mid >= 0 && y == H / 2) bus.sw = sw_mid[7:0];
      line(P, W, y == 0, y);
    end
    line(P, 0, 1'b0, 0);
  endtask

  initial begin
    int W, H, P;
    int lens[7];
    rst = 1'b1;
    bus.rx_hs = 0; bus.rx_vs = 0; bus.rx_dv = 0; bus.sw = '0;
    g_w = 0; g_h = 0; frames_ok = 0; bok = 0; px = 0; py = 0;
    repeat (3) step();
    check("rst_locked", bus.locked, 0);
    check("rst_addr",   bus.addr,   0);
    check("rst_border", bus.border, 0);
    rst = 1'b0;

    // Stable 800-clock lines: lock one clock after the third hs rise
    line(800, 0, 1'b0, 0);
    line(800, 0, 1'b0, 0);
    check("pre_lock", bus.locked, 0);
    drive(1'b1, 1'b0, 1'b0);
    check("lock_1clk",  bus.locked,   1);
    check("lock_len",   bus.line_len, 800);
    check("lock_addr0", bus.addr,     0);
    line_seg(0, 1'b0, 0, 1, 800);
    check("addr_end", bus.addr, 799);
    repeat (2) line(800, 0, 1'b0, 0);

    // One stray line tolerated; two consecutive misses force re-acquire at 801
    lens = '{801, 800, 800, 801, 801, 801, 801};
    foreach (lens[i]) line(lens[i], 0, 1'b0, 0);
    check("relock",      bus.locked,   1);
    check("relock_len",  bus.line_len, 801);
    check("relock_addr", bus.addr,     800);

    // hs lost: period saturates, back to idle, then full reacquire
    repeat (4100) drive(1'b0, 1'b0, 1'b0);
    check("sat_locked", bus.locked, 0);
    check("sat_addr",   bus.addr,   0);
    repeat (4) line(800, 0, 1'b0, 0);
    check("reacq",      bus.locked,   1);
    check("reacq_len",  bus.line_len, 800);
    check("reacq_addr", bus.addr,     799);

    // Filter select: ignored while unlocked, applied only at frame start
    rst = 1'b1; step(); rst = 1'b0;
    frames_ok = 0; bok = 0;
    bus.sw = 8'h03;
    frame(16, 6, 3, -1);
    check("coef_unlocked", bus.coef_sel, 8'h00);
    frame(16, 6, 3, 8'h1C);
    check("coef_hold", bus.coef_sel, 8'h03);
    frame(16, 6, 3, -1);
    check("coef_apply", bus.coef_sel, 8'h1C);

    // Random geometries including widths/heights below the kernel radius
    repeat (10) begin
      W = $urandom_range(1, 12);
      H = $urandom_range(1, 6);
      P = W + 8 + $urandom_range(0, 3);
      repeat (3) frame(P, W, H, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : -1);
    end

    // Reset mid-line while locked, with hs high across the release
    repeat (2) frame(16, 6, 3, -1);
    check("pre_rst_lock", bus.locked, 1);
    bok = 0;
    line_seg(6, 1'b0, 0, 0, 7);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    check("mid_rst_locked", bus.locked,   0);
    check("mid_rst_len",    bus.line_len, 0);
    check("mid_rst_addr",   bus.addr,     0);
    check("mid_rst_coef",   bus.coef_sel, 0);
    check("mid_rst_border", bus.border,   0);
    rst = 1'b0;
    frames_ok = 0;
    line_seg(0, 1'b0, 0, 1, 16);
    repeat (3) frame(16, 6, 3, -1);
    check("post_rst_lock", bus.locked,   1);
    check("post_rst_len",  bus.line_len, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
